// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the MEM stage of the 5-stage RISC-V core.
//   OP_LW / OP_SW     EX/MEM operation codes that may touch data memory
//   WB_REGWRITE/...   bit positions inside the 2-bit Wb control field
//   mem_state_t       data-memory handshake FSM states
//   is_load/is_store  access decode; the Mem_Read/Mem_Write flags are sticky
//                     upstream, so they only count together with the opcode
package core_pkg;

    localparam logic [3:0] OP_LW = 4'b0101;
    localparam logic [3:0] OP_SW = 4'b0110;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op, input logic mem_read);
        return (op == OP_LW) && mem_read;
    endfunction

    function automatic logic is_store(input logic [3:0] op, input logic mem_write);
        return (op == OP_SW) && mem_write;
    endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// dmem_req_fsm: req/ack handshake controller for the data-memory port.
//   clk_i, rst_i      core clock, asynchronous active-low reset
//   load_i, store_i   decoded access from the EX/MEM register
//   addr_i, wdata_i   access address and store data
//   dmem_ack_i        one-cycle completion pulse from memory
//   dmem_req_o/we/addr/wdata   memory request, held stable while BUSY
//   stall_o           hold the upstream pipeline this cycle
//   err_o             one-cycle pulse after a misaligned access or a timeout
//   complete_o        BUSY cycle in which ack arrives (capture edge follows)
//   abort_o           BUSY cycle in which the access times out
module dmem_req_fsm
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        complete_o,
    output logic        abort_o
);

    // Counter value of the last BUSY cycle before giving up on the memory.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic access;
    logic misaligned;

    assign access     = load_i | store_i;
    assign misaligned = access && (addr_i[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        stall_o    = 1'b0;
        complete_o = 1'b0;
        abort_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ack arriving while IDLE belongs to nobody and is dropped.
                if (access) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = BUSY;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = store_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                    end
                end
            end
            BUSY: begin
                // Ack is tested first so a late ack on the last cycle still completes.
                if (dmem_ack_i) begin
                    complete_o = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = 8'd0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = '0;
                    wdata_d    = '0;
                end else if (cnt_q == TimeoutLast) begin
                    abort_o = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign err_o        = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB pipeline register.
//   clk_i, rst_i                 core clock, asynchronous active-low reset
//   operation_i, Mem_Read_i,
//   Mem_Write_i                  EX/MEM opcode and (sticky) access flags
//   addr_data_i, write_data_i    ALU result / address and store data
//   MEM_WB_Wb_i, rd_i            write-back controls and destination register
//   dmem_*                       variable-latency data-memory req/ack port
//   stall_o                      hold PC/IF_ID/ID_EX/EX_MEM this cycle
//   RegWrite_o, MemtoReg_o,
//   alu_result_o, mem_data_o,
//   rd_o                         registered MEM/WB outputs
//   err_o                        one-cycle pulse on misaligned access or timeout
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  operation_i,
    input  logic        Mem_Read_i,
    input  logic        Mem_Write_i,
    input  logic [31:0] addr_data_i,
    input  logic [31:0] write_data_i,
    input  logic [1:0]  MEM_WB_Wb_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] mem_data_o,
    output logic [4:0]  rd_o,
    output logic        err_o
);

    logic load;
    logic store;
    logic access;
    logic complete;
    logic abort;

    assign load   = is_load(operation_i, Mem_Read_i);
    assign store  = is_store(operation_i, Mem_Write_i);
    assign access = load | store;

    dmem_req_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_dmem_req_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (load),
        .store_i      (store),
        .addr_i       (addr_data_i),
        .wdata_i      (write_data_i),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .complete_o   (complete),
        .abort_o      (abort)
    );

    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_data_q, mem_data_d;

    always_comb begin
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        mem_data_d = mem_data_q;

        if (complete) begin
            // EX/MEM inputs are still held by the stall, so they describe this access.
            regwrite_d = MEM_WB_Wb_i[WB_REGWRITE];
            memtoreg_d = MEM_WB_Wb_i[WB_MEMTOREG];
            rd_d       = rd_i;
            alu_d      = addr_data_i;
            if (load) begin
                mem_data_d = dmem_rdata_i;
            end
        end else if (access || stall_o || abort) begin
            // Bubble: the access is either in flight, misaligned or abandoned.
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            rd_d       = 5'd0;
        end else begin
            regwrite_d = MEM_WB_Wb_i[WB_REGWRITE];
            memtoreg_d = MEM_WB_Wb_i[WB_MEMTOREG];
            rd_d       = rd_i;
            alu_d      = addr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rd_q       <= 5'd0;
            alu_q      <= '0;
            mem_data_q <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign RegWrite_o   = regwrite_q;
    assign MemtoReg_o   = memtoreg_q;
    assign rd_o         = rd_q;
    assign alu_result_o = alu_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage (TIMEOUT = 4).
// Inputs change 1 ns after posedge; stall_o is sampled at negedge and the
// registered outputs 1 ns after posedge.
module tb_mem_wb_stage;
    import core_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  operation_i;
    logic        Mem_Read_i;
    logic        Mem_Write_i;
    logic [31:0] addr_data_i;
    logic [31:0] write_data_i;
    logic [1:0]  MEM_WB_Wb_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] alu_result_o;
    logic [31:0] mem_data_o;
    logic [4:0]  rd_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference MEM/WB contents.
    logic        m_rw;
    logic        m_m2r;
    logic [4:0]  m_rd;
    logic [31:0] m_alu;
    logic [31:0] m_mem;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .operation_i  (operation_i),
        .Mem_Read_i   (Mem_Read_i),
        .Mem_Write_i  (Mem_Write_i),
        .addr_data_i  (addr_data_i),
        .write_data_i (write_data_i),
        .MEM_WB_Wb_i  (MEM_WB_Wb_i),
        .rd_i         (rd_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_o      (stall_o),
        .RegWrite_o   (RegWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .alu_result_o (alu_result_o),
        .mem_data_o   (mem_data_o),
        .rd_o         (rd_o),
        .err_o        (err_o)
    );

    task automatic drive_nop();
        operation_i  = 4'b0000;
        Mem_Read_i   = 1'b0;
        Mem_Write_i  = 1'b0;
        addr_data_i  = '0;
        write_data_i = '0;
        MEM_WB_Wb_i  = 2'b00;
        rd_i         = 5'd0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
    endtask

    task automatic model_clear();
        m_rw  = 1'b0;
        m_m2r = 1'b0;
        m_rd  = 5'd0;
        m_alu = '0;
        m_mem = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive_nop();
        #12;
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o, RegWrite_o, MemtoReg_o,
             alu_result_o, mem_data_o, rd_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b alu=%h mem=%h rd=%0d err=%b, expected all 0",
                     dmem_req_o, alu_result_o, mem_data_o, rd_o, err_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    // One non-memory instruction; ack is driven to show it is ignored in IDLE.
    task automatic test_nonaccess(input logic [3:0] op, input logic mr, input logic mw,
                                  input logic [31:0] a, input logic [1:0] wb,
                                  input logic [4:0] rd, input logic ack);
        operation_i  = op;
        Mem_Read_i   = mr;
        Mem_Write_i  = mw;
        addr_data_i  = a;
        write_data_i = $urandom;
        MEM_WB_Wb_i  = wb;
        rd_i         = rd;
        dmem_ack_i   = ack;
        dmem_rdata_i = $urandom;
        @(negedge clk);
        n_cmp++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL nonaccess_stall: got stall=%b req=%b expected 0 0", stall_o, dmem_req_o);
        end
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        m_rw  = wb[1];
        m_m2r = wb[0];
        m_rd  = rd;
        m_alu = a;
        n_cmp++;
        if ({RegWrite_o, MemtoReg_o, rd_o, alu_result_o, mem_data_o, err_o}
            !== {m_rw, m_m2r, m_rd, m_alu, m_mem, 1'b0}) begin
            n_bad++;
            $display("FAIL nonaccess_wb: got rw=%b m2r=%b rd=%0d alu=%h mem=%h err=%b expected %b %b %0d %h %h 0",
                     RegWrite_o, MemtoReg_o, rd_o, alu_result_o, mem_data_o, err_o,
                     m_rw, m_m2r, m_rd, m_alu, m_mem);
        end
    endtask

    // Misaligned load/store: no request, no stall, bubble, err pulse next cycle.
    task automatic test_misaligned(input logic st, input logic [31:0] a, input logic [1:0] wb,
                                   input logic [4:0] rd);
        operation_i  = st ? OP_SW : OP_LW;
        Mem_Read_i   = st ? 1'($urandom) : 1'b1;
        Mem_Write_i  = st ? 1'b1 : 1'($urandom);
        addr_data_i  = a;
        write_data_i = $urandom;
        MEM_WB_Wb_i  = wb;
        rd_i         = rd;
        dmem_ack_i   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL misaligned_stall: got stall=%b req=%b expected 0 0", stall_o, dmem_req_o);
        end
        @(posedge clk);
        #1;
        m_rw  = 1'b0;
        m_m2r = 1'b0;
        m_rd  = 5'd0;
        n_cmp++;
        if ({err_o, dmem_req_o, RegWrite_o, MemtoReg_o, rd_o, alu_result_o, mem_data_o}
            !== {1'b1, 1'b0, m_rw, m_m2r, m_rd, m_alu, m_mem}) begin
            n_bad++;
            $display("FAIL misaligned_result: got err=%b req=%b rw=%b rd=%0d alu=%h mem=%h expected 1 0 0 0 %h %h",
                     err_o, dmem_req_o, RegWrite_o, rd_o, alu_result_o, mem_data_o, m_alu, m_mem);
        end
    endtask

    // Aligned access; ack_at = BUSY cycle carrying the ack (1..TIMEOUT), anything else = none.
    task automatic test_access(input logic st, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] wb, input logic [4:0] rd, input int ack_at,
                               input logic [31:0] rdata);
        int   stalls;
        int   busy_len;
        logic done;
        done     = (ack_at >= 1) && (ack_at <= TIMEOUT);
        busy_len = done ? ack_at : TIMEOUT;
        stalls   = 0;
        operation_i  = st ? OP_SW : OP_LW;
        Mem_Read_i   = st ? 1'($urandom) : 1'b1;
        Mem_Write_i  = st ? 1'b1 : 1'($urandom);
        addr_data_i  = a;
        write_data_i = wd;
        MEM_WB_Wb_i  = wb;
        rd_i         = rd;
        dmem_ack_i   = 1'($urandom);
        dmem_rdata_i = $urandom;
        @(negedge clk);
        n_cmp++;
        if (dmem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL access_idle_req: got %b expected 0", dmem_req_o);
        end
        if (stall_o === 1'b1) stalls++;
        @(posedge clk);
        #1;
        for (int c = 1; c <= busy_len; c++) begin
            dmem_ack_i   = (c == ack_at);
            dmem_rdata_i = (c == ack_at) ? rdata : $urandom;
            @(negedge clk);
            if (stall_o === 1'b1) stalls++;
            n_cmp++;
            if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, err_o, RegWrite_o, MemtoReg_o, rd_o}
                !== {1'b1, st, a, wd, 1'b0, 1'b0, 1'b0, 5'd0}) begin
                n_bad++;
                $display("FAIL access_busy_hold: cycle %0d got req=%b we=%b addr=%h wdata=%h err=%b rw=%b rd=%0d expected 1 %b %h %h 0 0 0",
                         c, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, err_o, RegWrite_o,
                         rd_o, st, a, wd);
            end
            @(posedge clk);
            #1;
        end
        dmem_ack_i = 1'b0;
        if (done) begin
            m_rw  = wb[1];
            m_m2r = wb[0];
            m_rd  = rd;
            m_alu = a;
            if (!st) m_mem = rdata;
        end else begin
            m_rw  = 1'b0;
            m_m2r = 1'b0;
            m_rd  = 5'd0;
        end
        n_cmp++;
        if (stalls != busy_len) begin
            n_bad++;
            $display("FAIL access_stall_count: got %0d cycles expected %0d", stalls, busy_len);
        end
        n_cmp++;
        if ({dmem_req_o, err_o} !== {1'b0, !done}) begin
            n_bad++;
            $display("FAIL access_end: got req=%b err=%b expected 0 %b", dmem_req_o, err_o, !done);
        end
        n_cmp++;
        if ({RegWrite_o, MemtoReg_o, rd_o, alu_result_o, mem_data_o}
            !== {m_rw, m_m2r, m_rd, m_alu, m_mem}) begin
            n_bad++;
            $display("FAIL access_wb: got rw=%b m2r=%b rd=%0d alu=%h mem=%h expected %b %b %0d %h %h",
                     RegWrite_o, MemtoReg_o, rd_o, alu_result_o, mem_data_o,
                     m_rw, m_m2r, m_rd, m_alu, m_mem);
        end
    endtask

    task automatic test_reset_busy();
        operation_i = OP_LW;
        Mem_Read_i  = 1'b1;
        addr_data_i = 32'h0000_0400;
        MEM_WB_Wb_i = 2'b11;
        rd_i        = 5'd3;
        dmem_ack_i  = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dmem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy_req: got %b expected 1", dmem_req_o);
        end
        #2;
        rst_i = 1'b0;
        drive_nop();
        #1;
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o, RegWrite_o, MemtoReg_o,
             alu_result_o, mem_data_o, rd_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_busy_outputs: got req=%b addr=%h alu=%h mem=%h expected all 0",
                     dmem_req_o, dmem_addr_o, alu_result_o, mem_data_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic test_back_to_back();
        test_access(1'b0, 32'h0000_0500, 32'h0, 2'b11, 5'd10, 2, 32'h1111_2222);
        test_access(1'b1, 32'h0000_0504, 32'h3333_4444, 2'b00, 5'd0, 1, 32'h0);
        test_access(1'b0, 32'h0000_0508, 32'h0, 2'b11, 5'd11, 1, 32'h5555_6666);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [3:0]  op;
            logic        mr;
            logic        mw;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            case (kind)
                0: begin
                    op = 4'($urandom);
                    mr = 1'($urandom);
                    mw = 1'($urandom);
                    if (op == OP_LW) mr = 1'b0;
                    if (op == OP_SW) mw = 1'b0;
                    test_nonaccess(op, mr, mw, a, 2'($urandom), 5'($urandom), 1'($urandom));
                end
                1, 2: begin
                    test_access(kind == 2, {a[31:2], 2'b00}, $urandom, 2'($urandom),
                                5'($urandom), int'($urandom_range(0, TIMEOUT + 1)), $urandom);
                end
                default: begin
                    a[1:0] = 2'($urandom_range(1, 3));
                    test_misaligned(1'($urandom), a, 2'($urandom), 5'($urandom));
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_nonaccess(4'b0000, 1'b0, 1'b0, 32'h0000_1234, 2'b10, 5'd5, 1'b0);
        // lw opcode without Mem_Read, and a stray Mem_Write flag on an ALU op
        test_nonaccess(OP_LW, 1'b0, 1'b1, 32'h0000_0044, 2'b10, 5'd6, 1'b1);
        test_nonaccess(4'b0011, 1'b1, 1'b1, 32'h0000_0048, 2'b10, 5'd8, 1'b0);
        test_access(1'b0, 32'h0000_0100, 32'h0, 2'b11, 5'd7, 3, 32'hDEAD_BEEF);
        test_access(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 2'b00, 5'd0, 1, 32'h0);
        test_misaligned(1'b0, 32'h0000_0102, 2'b11, 5'd9);
        test_nonaccess(4'b0000, 1'b0, 1'b0, 32'h0000_0077, 2'b10, 5'd12, 1'b0);
        test_access(1'b0, 32'h0000_0300, 32'h0, 2'b11, 5'd13, 0, 32'h0);
        test_nonaccess(4'b0000, 1'b0, 1'b0, 32'h0000_0078, 2'b10, 5'd14, 1'b0);
        test_access(1'b0, 32'h0000_0304, 32'h0, 2'b11, 5'd15, TIMEOUT, 32'hCAFE_F00D);
        test_back_to_back();
        test_reset_busy();
        test_nonaccess(4'b0000, 1'b0, 1'b0, 32'h0000_1234, 2'b10, 5'd5, 1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage RISC-V core.
- Consumes the EX/MEM register outputs (operation, Mem_Read/Mem_Write, address, store data, Wb bits, rd).
- Drives a variable-latency data-memory port with a req/ack handshake and stalls the pipeline while a load or store is outstanding.
- Registers the result for write-back.
- Adds a misalignment check and a bus timeout so a dead memory never hangs the core.

## Interface
- TIMEOUT, 16: max cycles in BUSY waiting for ack before abort; legal range 2..255.
- clk_i  in  1  core clock, all state on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- operation_i  in  4  EX/MEM operation code; 4'b0101 = lw, 4'b0110 = sw.
- Mem_Read_i  in  1  EX/MEM read flag; honoured only when operation_i = lw.
- Mem_Write_i  in  1  EX/MEM write flag; honoured only when operation_i = sw.
- addr_data_i  in  32  ALU result (memory address, or result for non-memory ops).
- write_data_i  in  32  store data.
- MEM_WB_Wb_i  in  2  [1] RegWrite, [0] MemtoReg.
- rd_i  in  5  destination register.
- dmem_req_o  out  1  memory request, held until ack or abort.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word address.
- dmem_wdata_o  out  32  store data.
- dmem_ack_i  in  1  memory completion, one-cycle pulse.
- dmem_rdata_i  in  32  load data, valid with ack.
- stall_o  out  1  hold PC/IF_ID/ID_EX/EX_MEM this cycle.
- RegWrite_o  out  1  registered write-back enable.
- MemtoReg_o  out  1  registered write-back mux select.
- alu_result_o  out  32  registered addr_data_i.
- mem_data_o  out  32  registered load data.
- rd_o  out  5  registered rd, also the MEM/WB forwarding rd.
- err_o  out  1  one-cycle pulse on misaligned access or timeout.

## Operation
- Access decode:
  - load = (operation_i == lw) & Mem_Read_i.
  - store = (operation_i == sw) & Mem_Write_i.
  - The read/write flags are sticky upstream, so an access is never recognised from the flags alone.
- Misaligned: access with addr_data_i[1:0] != 0.
- FSM states are IDLE and BUSY.
- IDLE, non-access instruction: MEM/WB captures the inputs on the next edge; mem_data_o keeps its old value; no stall.
- IDLE, aligned access:
  - stall_o = 1 combinationally.
  - On the edge: go to BUSY, set dmem_req_o = 1, latch dmem_we_o/addr/wdata.
  - MEM/WB loads a bubble (RegWrite_o = 0, MemtoReg_o = 0, rd_o = 0).
- IDLE, misaligned access:
  - No request, no stall.
  - MEM/WB loads a bubble.
  - err_o = 1 for the cycle after the edge.
- BUSY, ack = 0, counter < TIMEOUT-1:
  - stall_o = 1; counter increments.
  - MEM/WB loads a bubble each cycle.
  - dmem_* outputs stay stable.
- BUSY, ack = 1:
  - stall_o = 0.
  - On the edge: dmem_req_o = 0, state = IDLE, counter = 0.
  - MEM/WB captures Wb/rd/addr from the held inputs, and mem_data_o captures dmem_rdata_i (load).
  - For a store, mem_data_o is unchanged and RegWrite_o comes from the Wb input (normally 0).
- BUSY, ack = 0, counter = TIMEOUT-1:
  - stall_o = 0.
  - On the edge: drop the request, go to IDLE, load a bubble, pulse err_o.
  - The instruction is retired with no architectural effect.
- Simultaneous ack and timeout in the same cycle: ack wins; no err_o.
- dmem_ack_i in IDLE is ignored.
- The counter is 8 bits, saturating, and cleared on entry to BUSY.

## Timing
- Reset: every output is 0 and state = IDLE, asynchronously on rst_i low.
- Reset asserted mid-BUSY drops dmem_req_o immediately; the access is lost and memory must tolerate an abandoned request.
- Non-access latency: 1 cycle input to MEM/WB output.
- Access latency: 1 cycle to request, plus N cycles to ack, plus the capture edge.
  - Minimum is 2 cycles, with ack in the first BUSY cycle.
  - stall_o is high for exactly N cycles when ack arrives in BUSY cycle N, where N >= 1.
- Upstream must hold the EX/MEM inputs stable whenever stall_o = 1.
  - This block samples them again on the completion edge.
- stall_o is combinational from state, operation_i, Mem_Read_i/Mem_Write_i, addr_data_i[1:0], dmem_ack_i and the counter.
- Back-to-back accesses: the ack edge returns the FSM to IDLE; the next access requests one cycle later, so there is no same-cycle re-request.

## Structure
- Shared package core_pkg holds:
  - OP_LW = 4'b0101 and OP_SW = 4'b0110.
  - WB_REGWRITE = 1 and WB_MEMTOREG = 0 bit indices.
  - The mem_state_t enum {IDLE, BUSY}.
- One sub-module, dmem_req_fsm, owns:
  - state and counter;
  - dmem_req_o/we/addr/wdata;
  - stall_o, err_o;
  - a one-cycle complete/abort indication to the MEM/WB register logic in the top.

## Test plan
- add, rd = 5, addr_data_i = 0x1234 -> next cycle RegWrite_o = 1, alu_result_o = 0x1234, rd_o = 5, stall_o never high.
- lw at 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - stall_o is high 3 cycles and dmem_addr_o stays at 0x100 throughout;
  - then mem_data_o = 0xDEADBEEF, MemtoReg_o = 1, rd_o correct.
- sw at 0x200, wdata 0xA5A5A5A5, ack in the first BUSY cycle -> dmem_we_o = 1 for 1 cycle, stall 1 cycle, RegWrite_o = 0, err_o = 0.
- lw at 0x102 -> no dmem_req_o, err_o pulse of 1 cycle, bubble, no stall.
- lw with no ack and TIMEOUT = 4 -> stall 4 cycles, request drops, err_o pulses, bubble.
  - Repeat with ack arriving exactly on the 4th BUSY cycle -> normal completion, err_o = 0.
- rst_i low during BUSY -> dmem_req_o = 0 asynchronously, all outputs 0; after release a fresh add completes normally.
